// File: rtl/debug_uart_pkg.sv
// Shared encodings for the MOPS-Hub debug UART TX path: parity modes and FSM states.
package debug_uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // Mode 2'b11 is an alias for "no parity", so only the two explicit codes enable the bit.
    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/debug_uart_sync_fifo.sv
// Single-clock FIFO with registered level/full/empty flags and a dropped-write pulse.
// Read data is first-word fall-through so the consumer can latch it in the pop cycle.
module debug_uart_sync_fifo
    import debug_uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_Push,
    input  logic [DATA_BITS-1:0] i_Push_Data,
    input  logic                 i_Pop,
    output logic [DATA_BITS-1:0] o_Pop_Data,
    output logic                 o_Full,
    output logic                 o_Empty,
    output logic [LVL_W-1:0]     o_Level,
    output logic                 o_Overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]     level_q, level_d;
    logic                 full_q, empty_q, overflow_q;
    logic                 push_ok, pop_ok;

    // A write while full is dropped even if a pop frees a slot in the same cycle.
    assign push_ok = i_Push && !full_q;
    assign pop_ok  = i_Pop && !empty_q;

    always_comb begin
        level_d = level_q;
        if (push_ok && !pop_ok) begin
            level_d = level_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q    <= level_d;
            full_q     <= (level_d == LVL_W'(FIFO_DEPTH));
            empty_q    <= (level_d == '0);
            overflow_q <= i_Push && full_q;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (push_ok) mem_q[wr_ptr_q] <= i_Push_Data;
    end

    assign o_Pop_Data = mem_q[rd_ptr_q];
    assign o_Full     = full_q;
    assign o_Empty    = empty_q;
    assign o_Level    = level_q;
    assign o_Overflow = overflow_q;

endmodule

// File: rtl/debug_uart_tx_fifo.sv
// Debug UART transmitter: runtime divisor, parity and stop count, fed from a byte FIFO
// so queued bytes leave as back-to-back frames.
module debug_uart_tx_fifo
    import debug_uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int DIV_WIDTH   = 16,
    parameter int FIFO_DEPTH  = 16,
    parameter int DEFAULT_CPB = 87,
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic [DIV_WIDTH-1:0] i_Clks_Per_Bit,
    input  logic [1:0]           i_Parity_Mode,
    input  logic                 i_Two_Stop,
    input  logic                 i_Tx_DV,
    input  logic [DATA_BITS-1:0] i_Tx_Byte,
    output logic                 o_Tx_Ready,
    output logic                 o_Tx_Serial,
    output logic                 o_Tx_Active,
    output logic                 o_Tx_Done,
    output logic                 o_Overflow,
    output logic [LVL_W-1:0]     o_Fifo_Level
);

    localparam int IDX_W = $clog2(DATA_BITS);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("debug_uart_tx_fifo: DATA_BITS must be 5..9");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("debug_uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end
    if ($clog2(DEFAULT_CPB + 1) > DIV_WIDTH) begin : g_bad_default_cpb
        $error("debug_uart_tx_fifo: DEFAULT_CPB does not fit in DIV_WIDTH");
    end

    logic [2:0]           state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] cpb_q, cpb_d;
    logic [1:0]           par_mode_q, par_mode_d;
    logic                 two_stop_q, two_stop_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic                 par_bit_q, par_bit_d;
    logic                 serial_q, line_d;
    logic                 active_q, done_q, done_d;
    logic                 load;
    logic                 bit_last;
    logic [DIV_WIDTH-1:0] eff_cpb;
    logic [DATA_BITS-1:0] fifo_data;
    logic                 fifo_full, fifo_empty;

    debug_uart_sync_fifo #(
        .DATA_BITS  (DATA_BITS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_Clock     (i_Clock),
        .i_Reset     (i_Reset),
        .i_Push      (i_Tx_DV),
        .i_Push_Data (i_Tx_Byte),
        .i_Pop       (load),
        .o_Pop_Data  (fifo_data),
        .o_Full      (fifo_full),
        .o_Empty     (fifo_empty),
        .o_Level     (o_Fifo_Level),
        .o_Overflow  (o_Overflow)
    );

    // Divisors of 0 or 1 cannot produce a sensible bit period, so they run as 2.
    assign eff_cpb  = (i_Clks_Per_Bit < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : i_Clks_Per_Bit;
    assign bit_last = (cnt_q >= cpb_q - 1'b1);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cpb_d      = cpb_q;
        par_mode_d = par_mode_q;
        two_stop_d = two_stop_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        par_bit_d  = par_bit_q;
        done_d     = 1'b0;
        load       = 1'b0;

        if (state_q != ST_IDLE) cnt_d = bit_last ? '0 : cnt_q + 1'b1;

        case (state_q)
            ST_IDLE:  load = !fifo_empty;
            ST_START: begin
                if (bit_last) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                end
            end
            ST_DATA: begin
                if (bit_last) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
                        state_d    = parity_enabled(par_mode_q) ? ST_PARITY : ST_STOP;
                        stop_idx_d = 1'b0;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_last) begin
                    state_d    = ST_STOP;
                    stop_idx_d = 1'b0;
                end
            end
            ST_STOP: begin
                // Chain straight into the next START when more bytes are queued.
                if (bit_last) begin
                    if (two_stop_q && !stop_idx_q) begin
                        stop_idx_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                        load   = !fifo_empty;
                        if (fifo_empty) state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            state_d    = ST_START;
            cnt_d      = '0;
            shift_d    = fifo_data;
            cpb_d      = eff_cpb;
            par_mode_d = i_Parity_Mode;
            two_stop_d = i_Two_Stop;
            par_bit_d  = (^fifo_data) ^ (i_Parity_Mode == PAR_ODD);
        end
    end

    always_comb begin
        case (state_q)
            ST_START:  line_d = 1'b0;
            ST_DATA:   line_d = shift_q[0];
            ST_PARITY: line_d = par_bit_q;
            default:   line_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            cpb_q      <= DIV_WIDTH'(2);
            par_mode_q <= PAR_NONE;
            two_stop_q <= 1'b0;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            par_bit_q  <= 1'b0;
            serial_q   <= 1'b1;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cpb_q      <= cpb_d;
            par_mode_q <= par_mode_d;
            two_stop_q <= two_stop_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            par_bit_q  <= par_bit_d;
            serial_q   <= line_d;
            active_q   <= (state_q != ST_IDLE);
            done_q     <= done_d;
        end
    end

    assign o_Tx_Serial = serial_q;
    assign o_Tx_Active = active_q;
    assign o_Tx_Done   = done_q;
    assign o_Tx_Ready  = !fifo_full;

endmodule
